// File: rtl/sigdecode_z.sv
//------------------------------------------------------------------------------
// Module   : sigdecode_z (with package sigdecode_z_pkg)
// Purpose  : Unpacks the z field of an ML-DSA-87 signature. Each 160-bit
//            signature word holds 8 x 20-bit packed coefficients. The module
//            emits them as 24-bit values mod q, 4 per write, in two
//            consecutive writes per read word.
// Ports    : clk, rst               - clock, async active-high reset
//            zeroize                - synchronous clear to idle
//            sigdecode_z_enable     - start pulse, sampled in IDLE only
//            sig_base_addr          - first signature word (latched at start)
//            dest_base_addr         - first destination word (latched at start)
//            sig_rd_req/sig_rd_data - signature memory read port, latency 1
//            mem_wr_req/mem_wr_data - destination memory write port
//            sigdecode_z_done       - one-cycle completion pulse
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sigdecode_z_pkg;
    localparam int ABR_MEM_ADDR_WIDTH = 15;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'b00,
        RW_READ  = 2'b01,
        RW_WRITE = 2'b10
    } rw_cmd_e;

    typedef struct packed {
        rw_cmd_e                        rd_wr_en;
        logic [ABR_MEM_ADDR_WIDTH-1:0]  addr;
    } sig_mem_if_t;
endpackage

module sigdecode_z
    import sigdecode_z_pkg::*;
#(
    parameter int MLDSA_L        = 7,
    parameter int MLDSA_N        = 256,
    parameter int MLDSA_Q        = 8380417,
    parameter int GAMMA1         = 2**19,
    parameter int COEFF_W        = 20,
    parameter int REG_SIZE       = 24,
    parameter int API_ADDR_WIDTH = ABR_MEM_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      zeroize,
    input  logic                      sigdecode_z_enable,
    input  logic [API_ADDR_WIDTH-1:0] sig_base_addr,
    input  logic [API_ADDR_WIDTH-1:0] dest_base_addr,
    output sig_mem_if_t               sig_rd_req,
    input  logic [8*COEFF_W-1:0]      sig_rd_data,
    output sig_mem_if_t               mem_wr_req,
    output logic [4*REG_SIZE-1:0]     mem_wr_data,
    output logic                      sigdecode_z_done
);

    localparam int c_num_rd = (MLDSA_L * MLDSA_N) / 8;   // 224 read words
    localparam int c_num_wr = 2 * c_num_rd;              // 448 write words
    localparam int c_rd_w   = $clog2(c_num_rd);
    localparam int c_wr_w   = $clog2(c_num_wr + 1);

    localparam logic [c_rd_w-1:0]   c_rd_last  = c_rd_w'(c_num_rd - 1);
    localparam logic [c_wr_w-1:0]   c_wr_total = c_wr_w'(c_num_wr);
    localparam logic [REG_SIZE-1:0] c_gamma1   = REG_SIZE'(GAMMA1);
    localparam logic [REG_SIZE-1:0] c_q_plus_g = REG_SIZE'(MLDSA_Q + GAMMA1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                     state_q, state_d;
    logic [API_ADDR_WIDTH-1:0]  sig_base_q, sig_base_d;
    logic [API_ADDR_WIDTH-1:0]  dest_base_q, dest_base_d;
    logic [c_rd_w-1:0]          rd_cnt_q, rd_cnt_d;
    logic [c_wr_w-1:0]          wr_cnt_q, wr_cnt_d;
    logic                       phase_q, phase_d;     // 0: issue read this cycle
    logic                       rd_vld_q, rd_vld_d;   // sig_rd_data valid this cycle
    logic                       hi_pend_q, hi_pend_d; // hold register awaits decode
    logic [4*COEFF_W-1:0]       hold_q, hold_d;
    sig_mem_if_t                sig_rd_req_q, sig_rd_req_d;
    sig_mem_if_t                mem_wr_req_q, mem_wr_req_d;
    logic [4*REG_SIZE-1:0]      mem_wr_data_q, mem_wr_data_d;
    logic                       done_q, done_d;

    // Inverse of the encoder's t = GAMMA1 - z, folded back into [0, q).
    function automatic logic [REG_SIZE-1:0] decode_coeff(input logic [COEFF_W-1:0] t);
        logic [REG_SIZE-1:0] t_ext;
        t_ext = REG_SIZE'(t);
        if (t_ext <= c_gamma1) begin
            return c_gamma1 - t_ext;
        end
        return c_q_plus_g - t_ext;
    endfunction

    always_comb begin
        state_d       = state_q;
        sig_base_d    = sig_base_q;
        dest_base_d   = dest_base_q;
        rd_cnt_d      = rd_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        phase_d       = phase_q;
        rd_vld_d      = (sig_rd_req_q.rd_wr_en == RW_READ);
        hi_pend_d     = 1'b0;
        hold_d        = hold_q;
        sig_rd_req_d  = '{rd_wr_en: RW_IDLE, addr: '0};
        mem_wr_req_d  = '{rd_wr_en: RW_IDLE, addr: '0};
        mem_wr_data_d = '0;
        done_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                rd_cnt_d = '0;
                wr_cnt_d = '0;
                phase_d  = 1'b0;
                if (sigdecode_z_enable) begin
                    state_d     = RUN;
                    sig_base_d  = sig_base_addr;
                    dest_base_d = dest_base_addr;
                end
            end
            RUN: begin
                // Reads every other cycle so each word gets two write slots.
                phase_d = ~phase_q;
                if (!phase_q) begin
                    sig_rd_req_d.rd_wr_en = RW_READ;
                    sig_rd_req_d.addr     = ABR_MEM_ADDR_WIDTH'(sig_base_q + API_ADDR_WIDTH'(rd_cnt_q));
                    rd_cnt_d              = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == c_rd_last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // wr_cnt_q reaches the total while the last write is on the bus.
                if (wr_cnt_q == c_wr_total) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Write path: low half straight from the read data, high half from
        // the hold register one cycle later.
        if (rd_vld_q) begin
            for (int i = 0; i < 4; i++) begin
                mem_wr_data_d[i*REG_SIZE +: REG_SIZE] = decode_coeff(sig_rd_data[i*COEFF_W +: COEFF_W]);
            end
            hold_d                = sig_rd_data[8*COEFF_W-1:4*COEFF_W];
            hi_pend_d             = 1'b1;
            mem_wr_req_d.rd_wr_en = RW_WRITE;
            mem_wr_req_d.addr     = ABR_MEM_ADDR_WIDTH'(dest_base_q + API_ADDR_WIDTH'(wr_cnt_q));
            wr_cnt_d              = wr_cnt_q + 1'b1;
        end else if (hi_pend_q) begin
            for (int i = 0; i < 4; i++) begin
                mem_wr_data_d[i*REG_SIZE +: REG_SIZE] = decode_coeff(hold_q[i*COEFF_W +: COEFF_W]);
            end
            mem_wr_req_d.rd_wr_en = RW_WRITE;
            mem_wr_req_d.addr     = ABR_MEM_ADDR_WIDTH'(dest_base_q + API_ADDR_WIDTH'(wr_cnt_q));
            wr_cnt_d              = wr_cnt_q + 1'b1;
        end

        if (zeroize) begin
            state_d       = IDLE;
            sig_base_d    = '0;
            dest_base_d   = '0;
            rd_cnt_d      = '0;
            wr_cnt_d      = '0;
            phase_d       = 1'b0;
            rd_vld_d      = 1'b0;
            hi_pend_d     = 1'b0;
            hold_d        = '0;
            sig_rd_req_d  = '{rd_wr_en: RW_IDLE, addr: '0};
            mem_wr_req_d  = '{rd_wr_en: RW_IDLE, addr: '0};
            mem_wr_data_d = '0;
            done_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sig_base_q    <= '0;
            dest_base_q   <= '0;
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            phase_q       <= 1'b0;
            rd_vld_q      <= 1'b0;
            hi_pend_q     <= 1'b0;
            hold_q        <= '0;
            sig_rd_req_q  <= '{rd_wr_en: RW_IDLE, addr: '0};
            mem_wr_req_q  <= '{rd_wr_en: RW_IDLE, addr: '0};
            mem_wr_data_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sig_base_q    <= sig_base_d;
            dest_base_q   <= dest_base_d;
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            phase_q       <= phase_d;
            rd_vld_q      <= rd_vld_d;
            hi_pend_q     <= hi_pend_d;
            hold_q        <= hold_d;
            sig_rd_req_q  <= sig_rd_req_d;
            mem_wr_req_q  <= mem_wr_req_d;
            mem_wr_data_q <= mem_wr_data_d;
            done_q        <= done_d;
        end
    end

    assign sig_rd_req       = sig_rd_req_q;
    assign mem_wr_req       = mem_wr_req_q;
    assign mem_wr_data      = mem_wr_data_q;
    assign sigdecode_z_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sigdecode_z.sv
//------------------------------------------------------------------------------
// Module   : tb_sigdecode_z
// Purpose  : Self-checking bench for sigdecode_z. Expected reads and writes
//            are queued from a modular-arithmetic reference model when a
//            decode is started; a monitor pops and compares each access.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sigdecode_z;
    import sigdecode_z_pkg::*;

    localparam int AW     = ABR_MEM_ADDR_WIDTH;
    localparam int Q      = 8380417;
    localparam int GAMMA1 = 524288;
    localparam int NRD    = 224;

    typedef struct {
        logic [AW-1:0] addr;
        logic [95:0]   data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              zeroize = 1'b0;
    logic              sigdecode_z_enable = 1'b0;
    logic [AW-1:0]     sig_base_addr = '0;
    logic [AW-1:0]     dest_base_addr = '0;
    sig_mem_if_t       sig_rd_req;
    logic [159:0]      sig_rd_data = '0;
    sig_mem_if_t       mem_wr_req;
    logic [95:0]       mem_wr_data;
    logic              sigdecode_z_done;

    sigdecode_z dut (
        .clk                (clk),
        .rst                (rst),
        .zeroize            (zeroize),
        .sigdecode_z_enable (sigdecode_z_enable),
        .sig_base_addr      (sig_base_addr),
        .dest_base_addr     (dest_base_addr),
        .sig_rd_req         (sig_rd_req),
        .sig_rd_data        (sig_rd_data),
        .mem_wr_req         (mem_wr_req),
        .mem_wr_data        (mem_wr_data),
        .sigdecode_z_done   (sigdecode_z_done)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    int            e_edge = 0;
    bit            mon_en = 1'b0;
    int            done_cnt, done_cyc, first_rd, first_wr, last_wr;
    logic [AW-1:0] exp_rd[$];
    wr_t           exp_wr[$];
    logic [159:0]  mem [0:(1<<AW)-1];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [159:0] rand160();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: packed t encodes z = GAMMA1 - t; result is z reduced into [0, q).
    function automatic logic [23:0] ref_coeff(input int t);
        int v;
        v = GAMMA1 - t;
        if (v < 0) v = v + Q;
        return 24'(v);
    endfunction

    // Signature memory: request seen in cycle c is answered during cycle c+1.
    bit            rd_seen = 1'b0;
    logic [AW-1:0] rd_addr_s = '0;
    always @(negedge clk) begin
        rd_seen   = (sig_rd_req.rd_wr_en == RW_READ);
        rd_addr_s = sig_rd_req.addr;
    end
    always @(posedge clk) begin
        #1;
        if (rd_seen) sig_rd_data = mem[rd_addr_s];
        else         sig_rd_data = rand160();
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (sig_rd_req.rd_wr_en == RW_READ) begin
                if (first_rd < 0) first_rd = cyc;
                if (exp_rd.size() == 0) chk("rd_extra", 128'(sig_rd_req.addr), 128'hFFFF_FFFF);
                else chk("rd_addr", 128'(sig_rd_req.addr), 128'(exp_rd.pop_front()));
            end else begin
                chk("rd_idle_cmd", 128'(sig_rd_req), 128'd0);
            end
            if (mem_wr_req.rd_wr_en == RW_WRITE) begin
                wr_t e;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (exp_wr.size() == 0) chk("wr_extra", 128'(mem_wr_req.addr), 128'hFFFF_FFFF);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 128'(mem_wr_req.addr), 128'(e.addr));
                    chk("wr_data", 128'(mem_wr_data), 128'(e.data));
                end
            end else if (mem_wr_req.rd_wr_en != RW_IDLE) begin
                chk("wr_cmd", 128'(mem_wr_req.rd_wr_en), 128'(RW_WRITE));
            end
            if (sigdecode_z_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_run(input logic [AW-1:0] sb, input logic [AW-1:0] db);
        logic [AW-1:0] a;
        logic [159:0]  w;
        logic [95:0]   lo, hi;
        exp_rd.delete();
        exp_wr.delete();
        first_rd = -1; first_wr = -1; last_wr = -1; done_cnt = 0; done_cyc = -1;
        for (int r = 0; r < NRD; r++) begin
            a = sb + AW'(r);
            w = mem[a];
            for (int j = 0; j < 4; j++) begin
                lo[24*j +: 24] = ref_coeff(int'(w[20*j +: 20]));
                hi[24*j +: 24] = ref_coeff(int'(w[20*(j+4) +: 20]));
            end
            exp_rd.push_back(a);
            exp_wr.push_back('{addr: db + AW'(2*r),     data: lo});
            exp_wr.push_back('{addr: db + AW'(2*r + 1), data: hi});
        end
        @(negedge clk);
        sig_base_addr      = sb;
        dest_base_addr     = db;
        sigdecode_z_enable = 1'b1;
        e_edge             = cyc + 1;
        @(negedge clk);
        sigdecode_z_enable = 1'b0;
        sig_base_addr      = AW'($urandom());   // must have been latched already
        dest_base_addr     = AW'($urandom());
    endtask

    task automatic finish_run(input string tag, input bit pulse);
        int k;
        k = 0;
        while (done_cnt == 0 && k < 600) begin
            @(negedge clk);
            k++;
            sigdecode_z_enable = (pulse && cyc < e_edge + 440) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        sigdecode_z_enable = 1'b0;
        repeat (4) @(negedge clk);
        chk_int({tag, "_done_count"}, done_cnt, 1);
        chk_int({tag, "_done_cycle"}, done_cyc - e_edge, 451);
        chk_int({tag, "_first_rd"}, first_rd - e_edge, 1);
        chk_int({tag, "_first_wr"}, first_wr - e_edge, 3);
        chk_int({tag, "_last_wr"}, last_wr - e_edge, 450);
        chk_int({tag, "_rd_left"}, exp_rd.size(), 0);
        chk_int({tag, "_wr_left"}, exp_wr.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_req"}, 128'(sig_rd_req), 128'd0);
        chk({tag, "_wr_req"}, 128'(mem_wr_req), 128'd0);
        chk({tag, "_wr_data"}, 128'(mem_wr_data), 128'd0);
        chk({tag, "_done"}, 128'(sigdecode_z_done), 128'd0);
    endtask

    initial begin
        logic [159:0] w;
        int           z, t;
        int           tv[8];
        bit           busy;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // All-zero signature: every coefficient decodes to GAMMA1.
        for (int r = 0; r < NRD; r++) mem[r] = '0;
        start_run(AW'(0), AW'(0));
        for (int i = 0; i < exp_wr.size(); i++) exp_wr[i].data = {4{24'h080000}};
        finish_run("zero", 1'b0);

        // Boundary word at the start, random words after it.
        tv = '{32'h00000, 32'h80000, 32'h80001, 32'hFFFFF, 32'h7FFFF, 32'h00001, 32'h80002, 32'h40000};
        for (int j = 0; j < 8; j++) w[20*j +: 20] = 20'(tv[j]);
        mem[AW'('h200)] = w;
        for (int r = 1; r < NRD; r++) mem[AW'('h200 + r)] = rand160();
        start_run(AW'('h200), AW'('h600));
        exp_wr[0].data = {24'h77E002, 24'h7FE000, 24'h000000, 24'h080000};
        exp_wr[1].data = {24'h040000, 24'h7FDFFF, 24'h07FFFF, 24'h000001};
        finish_run("vector", 1'b0);

        // Random z in (-2^19, 2^19] packed by the reference encoder.
        for (int r = 0; r < NRD; r++) begin
            for (int j = 0; j < 8; j++) begin
                z = int'($urandom_range(0, 2*GAMMA1 - 1)) - (GAMMA1 - 1);
                t = GAMMA1 - z;
                w[20*j +: 20] = 20'(t);
            end
            mem[AW'('h100 + r)] = w;
        end
        start_run(AW'('h100), AW'('h40));
        finish_run("random", 1'b0);

        // Enable pulsed during RUN must not restart the decode.
        start_run(AW'('h100), AW'('h40));
        finish_run("pulse", 1'b1);

        // Zeroize mid-run.
        mon_en = 1'b0;
        start_run(AW'('h100), AW'('h40));
        while (cyc < e_edge + 199) @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk_outputs_zero("zeroize");
        busy = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (sig_rd_req.rd_wr_en != RW_IDLE || mem_wr_req.rd_wr_en != RW_IDLE || sigdecode_z_done) busy = 1'b1;
        end
        chk("zeroize_stays_idle", 128'(busy), 128'd0);
        mon_en = 1'b1;
        start_run(AW'('h200), AW'('h600));
        finish_run("post_zeroize", 1'b0);

        // Asynchronous reset during FLUSH.
        mon_en = 1'b0;
        start_run(AW'('h100), AW'('h40));
        while (cyc < e_edge + 448) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_outputs_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        busy = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sig_rd_req.rd_wr_en != RW_IDLE || mem_wr_req.rd_wr_en != RW_IDLE || sigdecode_z_done) busy = 1'b1;
        end
        chk("rst_stays_idle", 128'(busy), 128'd0);
        mon_en = 1'b1;
        start_run(AW'(0), AW'('h7FF0));   // destination wraps past the top
        for (int i = 0; i < exp_wr.size(); i++) exp_wr[i].data = {4{24'h080000}};
        finish_run("post_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sigdecode_z.md
# sigdecode_z

Decodes the packed z field of an ML-DSA-87 signature: 7 polynomials × 256 coefficients × 20 bits. It reads 160-bit words (8 packed coefficients) from signature memory. It writes each coefficient as a 24-bit value mod q into internal memory, 4 coefficients per write. It sits in the verify datapath between the signature buffer and the NTT/norm-check stages, and is the inverse of sigencode_z.

## Interface
Parameters:
- MLDSA_L, 7, number of z polynomials
- MLDSA_N, 256, coefficients per polynomial
- MLDSA_Q, 8380417, modulus
- GAMMA1, 2^19, z range bound
- COEFF_W, 20, packed coefficient width
- REG_SIZE, 24, unpacked coefficient width
- API_ADDR_WIDTH, ABR_MEM_ADDR_WIDTH, memory address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- zeroize  in  1  synchronous clear to idle
- sigdecode_z_enable  in  1  start pulse, sampled in IDLE only
- sig_base_addr  in  API_ADDR_WIDTH  first signature word, latched at start
- dest_base_addr  in  API_ADDR_WIDTH  first destination word, latched at start
- sig_rd_req  out  sig_mem_if_t  read request (rd_wr_en = RW_READ/RW_IDLE, addr)
- sig_rd_data  in  160  read data, valid one cycle after the request
- mem_wr_req  out  sig_mem_if_t  write request (RW_WRITE/RW_IDLE, addr)
- mem_wr_data  out  96  4 × 24-bit coefficients
- sigdecode_z_done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE → RUN when enable is high; base addresses are latched on that edge.
  - RUN issues a read every other cycle (cycles 0, 2, 4, … of RUN) with rd_cnt 0..223 and addr = sig_base + rd_cnt. RUN → FLUSH after read 223 is issued.
  - FLUSH lasts until write 447 has been presented, then → DONE.
  - DONE asserts done for one cycle, then → IDLE.
- Read data is consumed in the cycle it is valid:
  - Coefficients 0-3 are decoded and registered into mem_wr_data.
  - Raw bits [159:80] go to an 80-bit hold register.
  - In the next cycle, the hold register is decoded and registered as the second write.
- Bit order:
  - Packed coefficient i occupies sig_rd_data[20i+19:20i].
  - Output coefficient j occupies mem_wr_data[24j+23:24j].
  - The low write carries coefficients 0-3 and the high write carries coefficients 4-7.
- Write address: dest_base + wr_cnt, wr_cnt 0..447, strictly sequential. Polynomial p occupies offsets 64p..64p+63.
- Per-coefficient decode, for a 20-bit t:
  - if t ≤ GAMMA1, z = GAMMA1 − t;
  - else z = MLDSA_Q + GAMMA1 − t.
  - Result is 24 bits, zero-extended, always in [0, q). There is no norm rejection here.
- Enable while not in IDLE is ignored.
- Addresses wrap modulo 2^API_ADDR_WIDTH; there is no range check.
- zeroize, in any state, does all of the following on the next edge:
  - returns the FSM to IDLE;
  - clears counters, hold register and outputs;
  - suppresses done.
- rst does the same asynchronously.

## Timing
- Reset values:
  - sig_rd_req = {RW_IDLE, 0}
  - mem_wr_req = {RW_IDLE, 0}
  - mem_wr_data = 0
  - sigdecode_z_done = 0
  - FSM = IDLE
- All outputs are registered.
- With enable sampled at edge E:
  - first read presented in cycle E+1;
  - reads in cycles E+1, E+3, …, E+447;
  - first write in cycle E+3;
  - writes continuous, one per cycle, through E+450 (448 writes);
  - done high in cycle E+451 only;
  - a new enable is accepted from E+452.
- Throughput is 4 coefficients per cycle. sig_rd_req is RW_IDLE in cycles without a read.
- The memory read latency is fixed at 1. There is no backpressure.

## Test plan
- All-zero signature memory → 448 writes, every coefficient = 0x080000 (524288). done at E+451, exactly 1 cycle.
- Word with t = {0x00000, 0x80000, 0x80001, 0xFFFFF, 0x7FFFF, 0x00001, 0x80002, 0x40000} → low write {0x080000, 0x000000, 0x7FE000, 0x77E002}; high write {0x000001, 0x07FFFF, 0x7FDFFF, 0x040000}.
- Random z in (−2^19, 2^19], packed via the reference encode with sig_base = 0x100 and dest_base = 0x40 → all 1792 coefficients match z mod q. Reads at 0x100..0x1DF and writes at 0x40..0x1FF, sequential and gap-free.
- Enable pulsed repeatedly during RUN → no restart, no extra accesses, a single done.
- zeroize at cycle E+200 → next cycle both requests are RW_IDLE with zero data and no done. A fresh enable then runs a full correct decode.
- rst asserted mid-FLUSH → outputs reach reset values asynchronously, before the next clock edge. After release the block sits in IDLE until enable.
